torque_array: RTL and testbench

- Multi-wheel, backpressure-aware successor of the per-node torque force generator.
- For each of NUM_WHEELS wheels, streams one tangential (perpendicular-to-radius) drive force per wheel node, scaled by a per-wheel signed drive, a gain and a right shift, with saturation.
- Sits between the node-position registers and the force accumulator of the soft-body physics step.
- Adds valid/ready handshake, wheel/node index tags, saturation flags and a done pulse.

---
 rtl/torque_array.sv | 194 +++++++++++++++++++
 tb/tb_torque_array.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/torque_array.sv
`default_nettype none
// ============================================================================
// Module   : torque_array
// Purpose  : Streams one tangential drive force per wheel node, wheel-major,
//            with valid/ready handshake, index tags and saturation flag.
// Revision : 1.0  initial release
// ============================================================================
module torque_array #(
  parameter int NUM_WHEELS    = 2,
  parameter int NUM_NODES     = 10,
  parameter int POSITION_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int DRIVE_SIZE    = 3,
  parameter int TORQUE        = 4,
  parameter int TORQUE_SHIFT  = 0
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   begin_in,
  input  logic [NUM_WHEELS-1:0][DRIVE_SIZE-1:0]                  drive_in,
  input  logic [NUM_WHEELS-1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_x_in,
  input  logic [NUM_WHEELS-1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_y_in,
  input  logic [NUM_WHEELS-1:0][POSITION_SIZE-1:0]               axle_x_in,
  input  logic [NUM_WHEELS-1:0][POSITION_SIZE-1:0]               axle_y_in,
  input  logic                                                   force_ready_in,
  output logic signed [FORCE_SIZE-1:0]                           force_x_out,
  output logic signed [FORCE_SIZE-1:0]                           force_y_out,
  output logic [$clog2(NUM_WHEELS):0]                            wheel_idx_out,
  output logic [$clog2(NUM_NODES):0]                             node_idx_out,
  output logic                                                   force_valid_out,
  output logic                                                   sat_out,
  output logic                                                   busy_out,
  output logic                                                   done_out
);

  localparam int c_WI = $clog2(NUM_WHEELS) + 1;
  localparam int c_NI = $clog2(NUM_NODES) + 1;
  // Wide enough that difference * drive * gain can never overflow.
  localparam int c_PW = POSITION_SIZE + DRIVE_SIZE + 34;
  localparam logic [c_WI-1:0] c_LAST_W = c_WI'(NUM_WHEELS - 1);
  localparam logic [c_NI-1:0] c_LAST_N = c_NI'(NUM_NODES - 1);
  localparam logic signed [c_PW-1:0] c_GAIN = c_PW'(TORQUE);
  localparam logic signed [c_PW-1:0] c_FMAX = (c_PW'(1) <<< (FORCE_SIZE - 1)) - c_PW'(1);
  localparam logic signed [c_PW-1:0] c_FMIN = -c_FMAX - c_PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [NUM_WHEELS-1:0][DRIVE_SIZE-1:0] r_drive;
  logic [c_WI-1:0]                       r_wheel, w_sel_w;
  logic [c_NI-1:0]                       r_node, w_sel_n;
  logic signed [FORCE_SIZE-1:0]          r_fx, r_fy, w_fx, w_fy;
  logic                                  r_sat, w_sat_x, w_sat_y;
  logic                                  w_first, w_load, w_clear, w_last;

  logic signed [POSITION_SIZE-1:0] w_nx, w_ny, w_ax, w_ay;
  logic signed [DRIVE_SIZE-1:0]    w_drv;
  logic signed [c_PW-1:0]          w_dx, w_dy, w_drv_ext, w_raw_x, w_raw_y, w_sx, w_sy;

  assign w_last = (r_wheel == c_LAST_W) && (r_node == c_LAST_N);

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // In RUN the output is always valid, so a transfer is simply ready high.
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_sel_w     = r_wheel;
    w_sel_n     = r_node;
    case (r_state)
      S_IDLE: begin
        if (begin_in) begin
          w_state_nxt = S_RUN;
          w_first     = 1'b1;
          w_load      = 1'b1;
          w_sel_w     = '0;
          w_sel_n     = '0;
        end
      end
      S_RUN: begin
        if (force_ready_in) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_clear     = 1'b1;
          end else begin
            w_load = 1'b1;
            if (r_node == c_LAST_N) begin
              w_sel_w = r_wheel + c_WI'(1);
              w_sel_n = '0;
            end else begin
              w_sel_n = r_node + c_NI'(1);
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand select; the first node uses the incoming drive since it is latched on the same edge.
  always_comb begin
    w_nx  = '0;
    w_ny  = '0;
    w_ax  = '0;
    w_ay  = '0;
    w_drv = '0;
    for (int w = 0; w < NUM_WHEELS; w++) begin
      if (w_sel_w == c_WI'(w)) begin
        w_ax  = axle_x_in[w];
        w_ay  = axle_y_in[w];
        w_drv = w_first ? drive_in[w] : r_drive[w];
        for (int n = 0; n < NUM_NODES; n++) begin
          if (w_sel_n == c_NI'(n)) begin
            w_nx = nodes_x_in[w][n];
            w_ny = nodes_y_in[w][n];
          end
        end
      end
    end
  end

  assign w_dx      = c_PW'(w_nx) - c_PW'(w_ax);
  assign w_dy      = c_PW'(w_ny) - c_PW'(w_ay);
  assign w_drv_ext = c_PW'(w_drv);
  assign w_raw_x   = (-w_dy) * w_drv_ext * c_GAIN;
  assign w_raw_y   = w_dx * w_drv_ext * c_GAIN;
  assign w_sx      = w_raw_x >>> TORQUE_SHIFT;
  assign w_sy      = w_raw_y >>> TORQUE_SHIFT;

  always_comb begin
    w_sat_x = 1'b1;
    w_sat_y = 1'b1;
    if (w_sx > c_FMAX)      w_fx = c_FMAX[FORCE_SIZE-1:0];
    else if (w_sx < c_FMIN) w_fx = c_FMIN[FORCE_SIZE-1:0];
    else begin
      w_fx    = w_sx[FORCE_SIZE-1:0];
      w_sat_x = 1'b0;
    end
    if (w_sy > c_FMAX)      w_fy = c_FMAX[FORCE_SIZE-1:0];
    else if (w_sy < c_FMIN) w_fy = c_FMIN[FORCE_SIZE-1:0];
    else begin
      w_fy    = w_sy[FORCE_SIZE-1:0];
      w_sat_y = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_drive <= '0;
      r_wheel <= '0;
      r_node  <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (w_first) r_drive <= drive_in;
      if (w_load) begin
        r_wheel <= w_sel_w;
        r_node  <= w_sel_n;
        r_fx    <= w_fx;
        r_fy    <= w_fy;
        r_sat   <= w_sat_x | w_sat_y;
      end else if (w_clear) begin
        r_wheel <= '0;
        r_node  <= '0;
        r_fx    <= '0;
        r_fy    <= '0;
        r_sat   <= 1'b0;
      end
    end
  end

  assign force_x_out     = r_fx;
  assign force_y_out     = r_fy;
  assign wheel_idx_out   = r_wheel;
  assign node_idx_out    = r_node;
  assign sat_out         = r_sat;
  assign force_valid_out = (r_state == S_RUN);
  assign busy_out        = (r_state == S_RUN);
  assign done_out        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_torque_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_torque_array
// Purpose  : Scoreboard bench for torque_array (shift 0 and shift 3 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_torque_array;
  localparam int NW = 2;
  localparam int NN = 10;
  localparam int PS = 8;
  localparam int FS = 8;
  localparam int DS = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, begin_in, force_ready_in;
  logic [NW-1:0][DS-1:0]         drive_in;
  logic [NW-1:0][NN-1:0][PS-1:0] nodes_x_in, nodes_y_in;
  logic [NW-1:0][PS-1:0]         axle_x_in, axle_y_in;
  logic signed [FS-1:0] fx, fy, fx3, fy3;
  logic [1:0] widx, widx3;
  logic [4:0] nidx, nidx3;
  logic valid, sat, busy, done, valid3, sat3, busy3, done3;

  torque_array #(.NUM_WHEELS(NW), .NUM_NODES(NN), .POSITION_SIZE(PS), .FORCE_SIZE(FS),
                 .DRIVE_SIZE(DS), .TORQUE(4), .TORQUE_SHIFT(0)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in), .drive_in(drive_in),
    .nodes_x_in(nodes_x_in), .nodes_y_in(nodes_y_in), .axle_x_in(axle_x_in),
    .axle_y_in(axle_y_in), .force_ready_in(force_ready_in), .force_x_out(fx),
    .force_y_out(fy), .wheel_idx_out(widx), .node_idx_out(nidx),
    .force_valid_out(valid), .sat_out(sat), .busy_out(busy), .done_out(done));

  torque_array #(.NUM_WHEELS(NW), .NUM_NODES(NN), .POSITION_SIZE(PS), .FORCE_SIZE(FS),
                 .DRIVE_SIZE(DS), .TORQUE(4), .TORQUE_SHIFT(3)) u_shift (
    .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in), .drive_in(drive_in),
    .nodes_x_in(nodes_x_in), .nodes_y_in(nodes_y_in), .axle_x_in(axle_x_in),
    .axle_y_in(axle_y_in), .force_ready_in(force_ready_in), .force_x_out(fx3),
    .force_y_out(fy3), .wheel_idx_out(widx3), .node_idx_out(nidx3),
    .force_valid_out(valid3), .sat_out(sat3), .busy_out(busy3), .done_out(done3));

  typedef struct {
    int w; int n; int fx; int fy; int sat; int fx3; int fy3; int sat3;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   px[NW][NN], py[NW][NN], axv[NW], ayv[NW];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfer_cnt = 0;
  bit   prev_last = 1'b0;
  bit   exp_done;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference: tangential force (-dy, dx) * drive * 4, floor shift, clip to 8 bits.
  function automatic void model(input int w, input int n, input int drv, input int sh,
                                output int ofx, output int ofy, output int osat);
    int dx, dy, sx, sy;
    dx  = px[w][n] - axv[w];
    dy  = py[w][n] - ayv[w];
    sx  = (-dy * drv * 4) >>> sh;
    sy  = (dx * drv * 4) >>> sh;
    ofx = clip(sx);
    ofy = clip(sy);
    osat = (ofx != sx || ofy != sy) ? 1 : 0;
  endfunction

  task automatic start_sweep(input int d0, input int d1);
    exp_t x;
    @(posedge clk_in); #1;
    drive_in[0] = 3'(d0);
    drive_in[1] = 3'(d1);
    begin_in    = 1'b1;
    for (int w = 0; w < NW; w++)
      for (int n = 0; n < NN; n++) begin
        x.w = w; x.n = n;
        model(w, n, (w == 0) ? d0 : d1, 0, x.fx, x.fy, x.sat);
        model(w, n, (w == 0) ? d0 : d1, 3, x.fx3, x.fy3, x.sat3);
        sb.push_back(x);
      end
    xfer_cnt = 0;
    @(posedge clk_in); #1;
    begin_in = 1'b0;
    @(negedge clk_in);
    check("first_valid_latency", valid, 1);
  endtask

  task automatic wait_done(input bit tog);
    bit seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(posedge clk_in); #1;
      if (done) seen = 1'b1;
      else if (tog) begin
        begin_in = ~begin_in;
        drive_in = '1;
      end
    end
    check("sweep_done_seen", seen, 1);
    if (tog) begin
      begin_in = 1'b1;
      @(posedge clk_in); #1;
      begin_in = 1'b0;
    end
    check("transfers_per_sweep", xfer_cnt, NW * NN);
    repeat (3) @(negedge clk_in);
    check("idle_outputs_zero", {valid, busy, done, sat, fx, fy, widx, nidx}, 0);
  endtask

  task automatic wait_xfers(input int target);
    for (int k = 0; k < 200 && xfer_cnt != target; k++) @(posedge clk_in);
    check("reach_transfer", xfer_cnt, target);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) prev_last = 1'b0;
    else begin
      exp_done  = prev_last;
      prev_last = 1'b0;
      if (done || exp_done) begin
        check("done_pulse", done, exp_done);
        check("busy_at_done", busy, 0);
        check("shift_done_pulse", done3, exp_done);
      end
      if (valid) begin
        if (sb.size() == 0) check("unexpected_valid", valid, 0);
        else begin
          e = sb[0];
          check("wheel_idx", widx, e.w);
          check("node_idx", nidx, e.n);
          check("force_x", fx, e.fx);
          check("force_y", fy, e.fy);
          check("sat", sat, e.sat);
          check("busy_in_run", busy, 1);
          check("shift_valid", valid3, 1);
          check("shift_force_x", fx3, e.fx3);
          check("shift_force_y", fy3, e.fy3);
          check("shift_sat", sat3, e.sat3);
          if (force_ready_in) begin
            sb.delete(0);
            xfer_cnt++;
            if (sb.size() == 0) prev_last = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rst_in = 1'b0; begin_in = 1'b0; force_ready_in = 1'b1; drive_in = '0;
    // Wheel 0: axle origin, hand-picked first nodes; wheel 1: offset axle, saturating node 0.
    axv[0] = 0;   ayv[0] = 0;
    axv[1] = -10; ayv[1] = 20;
    px[0][0] = 3;  py[0][0] = 5;
    px[0][1] = 0;  py[0][1] = 5;
    px[1][0] = 90; py[1][0] = -80;
    for (int n = 2; n < NN; n++) begin px[0][n] = n * 7 - 30; py[0][n] = 25 - n * 6; end
    for (int n = 1; n < NN; n++) begin px[1][n] = n * 9 - 40; py[1][n] = 30 - n * 5; end
    for (int w = 0; w < NW; w++) begin
      axle_x_in[w] = 8'(axv[w]);
      axle_y_in[w] = 8'(ayv[w]);
      for (int n = 0; n < NN; n++) begin
        nodes_x_in[w][n] = 8'(px[w][n]);
        nodes_y_in[w][n] = 8'(py[w][n]);
      end
    end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_outputs", {valid, busy, done, sat, fx, fy, widx, nidx}, 0);
    @(posedge clk_in); #1 rst_in = 1'b1;

    // Basic sweep plus positive saturation on wheel 1 node 0.
    start_sweep(1, 3);
    check("basic_fx", fx, -20);
    check("basic_fy", fy, 12);
    check("basic_sat", sat, 0);
    check("basic_shift_fx", fx3, -3);
    wait_done(1'b0);

    // Backpressure at transfer 3, negative saturation.
    start_sweep(2, -3);
    wait_xfers(3);
    #1 force_ready_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      check("stall_node_idx", nidx, 3);
    end
    @(posedge clk_in); #1 force_ready_in = 1'b1;
    wait_done(1'b0);

    // Ignored begin/drive during RUN and DONE; drive 0 on wheel 1.
    start_sweep(-2, 0);
    wait_done(1'b1);
    drive_in = '0;

    // Abort mid-sweep, then restart.
    start_sweep(1, 1);
    wait_xfers(7);
    #1 rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    sb.delete();
    check("abort_outputs_zero", {valid, busy, done, sat, fx, fy, widx, nidx}, 0);
    repeat (4) begin
      @(negedge clk_in);
      check("no_done_after_abort", done, 0);
    end
    start_sweep(-1, 2);
    check("restart_wheel", widx, 0);
    check("restart_node", nidx, 0);
    wait_done(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
